segasys1_sprrom_arb: RTL and testbench
======================================

# segasys1_sprrom_arb

Arbiter and request sequencer for the sprite chip ROM. Accepts byte reads from the sprite renderer and byte writes from the ROM download port, and serializes both onto one 16-bit, variable-latency memory port with a req/ack handshake. Sits between the sprite engine's chip-ROM address/data pins and the board-level memory controller. An optional one-word read cache absorbs the paired-byte accesses the renderer makes.

## Interface
- No parameters; address widths are fixed by the sprite ROM map (256 KiB bytes, 128 Ki words).
- `VCLKx8` in 1: sole clock; all logic on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `spr_rd` in 1: one-cycle sprite read request.
- `spr_ad` in 18: sprite byte address `{bank, offset}`.
- `spr_dt` out 8: read byte; valid when `spr_rdy` is high; held until the next `spr_rdy`.
- `spr_rdy` out 1: one-cycle read-complete strobe.
- `dl_we` in 1: one-cycle download write strobe.
- `dl_ad` in 18: download byte address.
- `dl_dt` in 8: download byte.
- `dl_busy` out 1: high from write accept until the memory ack.
- `mem_req` out 1: memory request; a level, held until ack.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_ad` out 17: word address, equal to byte address[17:1].
- `mem_be` out 2: byte enables, bit0 → `[7:0]`, bit1 → `[15:8]`; always `11` on reads.
- `mem_wd` out 16: write data, with the byte replicated on both lanes.
- `mem_rd` in 16: read word; valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: one-cycle completion from the memory controller.

## Operation
- Byte lane mapping: `ad[0]=0` selects `[7:0]`; `ad[0]=1` selects `[15:8]`.
- Pending registers:
  - Sprite: address plus a flag.
  - Download: address, data plus a flag.
  - A request is accepted when its strobe is high and its pending flag is clear.
  - A strobe arriving while its own flag is set is ignored. Sprite callers must wait for `spr_rdy`; download callers must respect `dl_busy`.
- FSM states: `IDLE`, `RD`, `WR`.
  - `IDLE`: the download pending flag wins over the sprite pending flag. Grant loads `mem_*` and sets `mem_req`, then goes to `WR` or `RD`.
  - `RD`/`WR`: hold all `mem_*` outputs stable. On `mem_ack`, clear `mem_req`, clear the pending flag and return to `IDLE`.
  - `RD` on ack: register the selected byte into `spr_dt` and pulse `spr_rdy`.
- A strobe arriving in the same cycle as `IDLE` is evaluated is accepted and granted on that same edge (no extra bubble).
- Simultaneous `spr_rd` and `dl_we` are both accepted; the download is granted first.
- A `mem_ack` with no outstanding request is ignored.
- Reset, including mid-transaction:
  - FSM → `IDLE`; all pending flags and the cache valid bit are cleared.
  - `mem_req=0`, `mem_we=0`, `mem_ad=0`, `mem_be=0`, `mem_wd=0`, `spr_dt=0`, `spr_rdy=0`, `dl_busy=0`.
  - A late `mem_ack` arriving after reset is ignored.

## Timing
- Miss read: `spr_rd` sampled at edge t → `mem_req` high after t (if `IDLE`) → ack sampled at edge t+k → `spr_rdy`/`spr_dt` valid in cycle t+k+1. Minimum latency is 2 cycles with a same-cycle ack.
- Write: `dl_busy` rises after the accept edge and falls after the ack edge.
- `mem_req` falls in the cycle after ack; a new grant may assert it again in that same cycle.

## Configuration
- `SPRROM_CACHE_EN` defined: adds one tagged word register (valid, tag = address[17:1], 16-bit data).
  - Filled on every `RD` ack.
  - Sprite read hit: `spr_rdy` follows in the next cycle, no memory access, handled regardless of FSM state.
  - A download write whose address[17:1] matches the tag clears valid at the accept edge.
- Undefined: every sprite read goes to memory; no tag logic is present.

## Structure
- Shared package `segasys1_pkg` holds:
  - FSM state encoding;
  - `SPRROM_AW = 18`;
  - `SPRROM_WAW = 17`;
  - byte-lane select constants.
- Natural sub-module: `segasys1_sprrom_cache`, containing the tag/valid/data registers and the hit compare. It is instantiated only under the macro.

## Test plan
- Miss read: `spr_rd` with `spr_ad=18'h00003`; memory returns `16'hA55A` after 3 cycles → `mem_ad=17'h00001`, `mem_be=11`; `spr_dt=8'hA5` one cycle after ack.
- Write: `dl_we` with `dl_ad=18'h20000`, `dl_dt=8'h3C` → `mem_we=1`, `mem_ad=17'h10000`, `mem_be=01`, `mem_wd=16'h3C3C`; `dl_busy` drops after ack.
- Collision: `spr_rd` and `dl_we` in the same cycle → write transaction first, then read; exactly one `spr_rdy`.
- Cache (macro on): read `18'h00002` then `18'h00003` → second read gives `spr_rdy` after 1 cycle and `mem_req` stays low; a write to `18'h00002` then a read of `18'h00003` → new memory read.
- Reset: assert `RESET_N=0` mid `RD` with `mem_req` high → all outputs 0 immediately; ack after release is ignored; no `spr_rdy`.
- Back-to-back: `spr_rd` re-strobed before `spr_rdy` → ignored; one `mem_req` and one `spr_rdy`.

Source files
------------

// File: rtl/segasys1_pkg.sv
// Shared definitions for the sprite chip-ROM arbiter: FSM state encoding,
// ROM address widths and byte-lane helpers.
package segasys1_pkg;

    localparam int SPRROM_AW  = 18;   // byte address width (256 KiB)
    localparam int SPRROM_WAW = 17;   // word address width (128 Ki words)

    // Arbiter sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } sprrom_state_e;

    // Byte lane selected by address bit 0
    localparam logic       LANE_LO = 1'b0;   // word bits [7:0]
    localparam logic       LANE_HI = 1'b1;   // word bits [15:8]
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    // Byte enable for a single-byte write in the given lane
    function automatic logic [1:0] lane_be(input logic sel);
        return (sel == LANE_HI) ? BE_HI : BE_LO;
    endfunction

    // Extract the byte of a word selected by address bit 0
    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic sel);
        return (sel == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/segasys1_sprrom_arb_if.sv
// Bus bundle for the sprite ROM arbiter: sprite read port, download write
// port and the 16-bit req/ack memory port. The arbiter uses the master
// modport; the renderer/download/memory side uses the slave modport.
interface segasys1_sprrom_arb_if;
    import segasys1_pkg::*;

    // Sprite renderer read port
    logic                  spr_rd;
    logic [SPRROM_AW-1:0]  spr_ad;
    logic [7:0]            spr_dt;
    logic                  spr_rdy;

    // ROM download write port
    logic                  dl_we;
    logic [SPRROM_AW-1:0]  dl_ad;
    logic [7:0]            dl_dt;
    logic                  dl_busy;

    // Memory controller port
    logic                  mem_req;
    logic                  mem_we;
    logic [SPRROM_WAW-1:0] mem_ad;
    logic [1:0]            mem_be;
    logic [15:0]           mem_wd;
    logic [15:0]           mem_rd;
    logic                  mem_ack;

    modport master (
        input  spr_rd, spr_ad, dl_we, dl_ad, dl_dt, mem_rd, mem_ack,
        output spr_dt, spr_rdy, dl_busy, mem_req, mem_we, mem_ad, mem_be, mem_wd
    );

    modport slave (
        output spr_rd, spr_ad, dl_we, dl_ad, dl_dt, mem_rd, mem_ack,
        input  spr_dt, spr_rdy, dl_busy, mem_req, mem_we, mem_ad, mem_be, mem_wd
    );

endinterface

// File: rtl/segasys1_sprrom_cache.sv
// One-word tagged read cache for the sprite ROM arbiter. Holds the last word
// fetched by a sprite read so the paired-byte access that follows can be
// answered without touching memory. Only instantiated with SPRROM_CACHE_EN.
module segasys1_sprrom_cache
    import segasys1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill,
    input  logic [SPRROM_WAW-1:0] fill_tag,
    input  logic [15:0]           fill_data,
    input  logic                  inval,
    input  logic [SPRROM_WAW-1:0] inval_tag,
    input  logic [SPRROM_WAW-1:0] lookup_tag,
    output logic                  hit,
    output logic [15:0]           hit_data
);

    logic                  valid_q, valid_d;
    logic [SPRROM_WAW-1:0] tag_q, tag_d;
    logic [15:0]           data_q, data_d;

    // Fill on read completion; a matching download write drops the line.
    // Invalidate is applied after fill so a same-cycle write always wins.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end
        if (inval && (tag_d == inval_tag)) begin
            valid_d = 1'b0;
        end
    end

    // Line registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    // A lookup colliding with a same-cycle write to that word must miss so
    // the read observes the written data.
    assign hit      = valid_q && (tag_q == lookup_tag) && !(inval && (inval_tag == lookup_tag));
    assign hit_data = data_q;

endmodule

// File: rtl/segasys1_sprrom_arb.sv
// Sprite chip-ROM arbiter: serializes sprite byte reads and download byte
// writes onto one 16-bit req/ack memory port. Downloads take priority.
// Optional macro SPRROM_CACHE_EN adds a one-word read cache.
module segasys1_sprrom_arb
    import segasys1_pkg::*;
(
    input  logic                  VCLKx8,
    input  logic                  RESET_N,
    segasys1_sprrom_arb_if.master bus
);

    sprrom_state_e         state_q, state_d;
    logic                  spr_pend_q, spr_pend_d;
    logic [SPRROM_AW-1:0]  spr_ad_q, spr_ad_d;
    logic                  dl_pend_q, dl_pend_d;
    logic [SPRROM_AW-1:0]  dl_ad_q, dl_ad_d;
    logic [7:0]            dl_dt_q, dl_dt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [SPRROM_WAW-1:0] mem_ad_q, mem_ad_d;
    logic [1:0]            mem_be_q, mem_be_d;
    logic [15:0]           mem_wd_q, mem_wd_d;
    logic [7:0]            spr_dt_q, spr_dt_d;
    logic                  spr_rdy_q, spr_rdy_d;

    logic                  spr_acc;
    logic                  dl_acc;
    logic                  spr_hit;
    logic [15:0]           hit_word;

`ifdef SPRROM_CACHE_EN
    logic cache_hit;

    segasys1_sprrom_cache u_cache (
        .clk        (VCLKx8),
        .rst_n      (RESET_N),
        .fill       ((state_q == RD) && bus.mem_ack),
        .fill_tag   (spr_ad_q[SPRROM_AW-1:1]),
        .fill_data  (bus.mem_rd),
        .inval      (dl_acc),
        .inval_tag  (bus.dl_ad[SPRROM_AW-1:1]),
        .lookup_tag (bus.spr_ad[SPRROM_AW-1:1]),
        .hit        (cache_hit),
        .hit_data   (hit_word)
    );

    // Hits are served outside the FSM, whatever it is doing
    assign spr_hit = bus.spr_rd && !spr_pend_q && cache_hit;
`else
    assign spr_hit  = 1'b0;
    assign hit_word = 16'h0000;
`endif

    // A strobe is taken only while its own pending slot is empty
    assign spr_acc = bus.spr_rd && !spr_pend_q && !spr_hit;
    assign dl_acc  = bus.dl_we && !dl_pend_q;

    // Accept requests, grant in IDLE (downloads first) and retire on ack.
    // Grant looks at the post-accept pending state so a strobe arriving
    // while IDLE is granted on the same edge.
    always_comb begin
        state_d    = state_q;
        spr_pend_d = spr_pend_q;
        spr_ad_d   = spr_ad_q;
        dl_pend_d  = dl_pend_q;
        dl_ad_d    = dl_ad_q;
        dl_dt_d    = dl_dt_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_ad_d   = mem_ad_q;
        mem_be_d   = mem_be_q;
        mem_wd_d   = mem_wd_q;
        spr_dt_d   = spr_dt_q;
        spr_rdy_d  = 1'b0;

        if (spr_acc) begin
            spr_pend_d = 1'b1;
            spr_ad_d   = bus.spr_ad;
        end
        if (dl_acc) begin
            dl_pend_d = 1'b1;
            dl_ad_d   = bus.dl_ad;
            dl_dt_d   = bus.dl_dt;
        end
        if (spr_hit) begin
            spr_dt_d  = lane_byte(hit_word, bus.spr_ad[0]);
            spr_rdy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (dl_pend_d) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    mem_ad_d  = dl_ad_d[SPRROM_AW-1:1];
                    mem_be_d  = lane_be(dl_ad_d[0]);
                    mem_wd_d  = {dl_dt_d, dl_dt_d};
                    state_d   = WR;
                end else if (spr_pend_d) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                    mem_ad_d  = spr_ad_d[SPRROM_AW-1:1];
                    mem_be_d  = BE_BOTH;
                    state_d   = RD;
                end
            end
            RD: begin
                if (bus.mem_ack) begin
                    mem_req_d  = 1'b0;
                    spr_pend_d = 1'b0;
                    spr_dt_d   = lane_byte(bus.mem_rd, spr_ad_q[0]);
                    spr_rdy_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            WR: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    dl_pend_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pending slots and registered outputs
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            spr_pend_q <= 1'b0;
            spr_ad_q   <= '0;
            dl_pend_q  <= 1'b0;
            dl_ad_q    <= '0;
            dl_dt_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_ad_q   <= '0;
            mem_be_q   <= '0;
            mem_wd_q   <= '0;
            spr_dt_q   <= '0;
            spr_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            spr_pend_q <= spr_pend_d;
            spr_ad_q   <= spr_ad_d;
            dl_pend_q  <= dl_pend_d;
            dl_ad_q    <= dl_ad_d;
            dl_dt_q    <= dl_dt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_ad_q   <= mem_ad_d;
            mem_be_q   <= mem_be_d;
            mem_wd_q   <= mem_wd_d;
            spr_dt_q   <= spr_dt_d;
            spr_rdy_q  <= spr_rdy_d;
        end
    end

    assign bus.mem_req = mem_req_q;
    assign bus.mem_we  = mem_we_q;
    assign bus.mem_ad  = mem_ad_q;
    assign bus.mem_be  = mem_be_q;
    assign bus.mem_wd  = mem_wd_q;
    assign bus.spr_dt  = spr_dt_q;
    assign bus.spr_rdy = spr_rdy_q;
    assign bus.dl_busy = dl_pend_q;

endmodule

// File: tb/tb_segasys1_sprrom_arb.sv
// Testbench for segasys1_sprrom_arb. Byte-level shadow ROM is the reference;
// a behavioural memory controller answers requests with programmable latency.
module tb_segasys1_sprrom_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    segasys1_sprrom_arb_if bus();

    segasys1_sprrom_arb dut (
        .VCLKx8  (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [16:0] ad;
        logic [1:0]  be;
        logic [15:0] wd;
    } req_t;

    req_t        req_log[$];
    logic [7:0]  shadow [int];
    logic [15:0] mem_words [int];
    int          resp_lat   = 0;
    bit          resp_en    = 1'b1;
    bit          inject_ack = 1'b0;
    logic [15:0] inject_rd  = 16'h0;
    int          hold_viol  = 0;
    int          rdy_count  = 0;
    bit          mc_valid   = 1'b0;
    logic [16:0] mc_tag     = '0;

    // Power-on ROM contents, byte granular
    function automatic logic [7:0] init_byte(input logic [17:0] a);
        return a[7:0] ^ {a[17:16], a[13:8]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [17:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return init_byte(a);
    endfunction

    function automatic logic [15:0] ctl_word(input logic [16:0] w);
        if (mem_words.exists(int'(w))) return mem_words[int'(w)];
        return {init_byte({w, 1'b1}), init_byte({w, 1'b0})};
    endfunction

    function automatic bit model_hit(input logic [17:0] a);
`ifdef SPRROM_CACHE_EN
        return mc_valid && (mc_tag == a[17:1]);
`else
        return (a === 18'hxxxxx);
`endif
    endfunction

    // Count read-complete strobes
    always @(posedge clk) begin
        #1;
        if (bus.spr_rdy === 1'b1) rdy_count++;
    end

    // Behavioural memory controller
    initial begin : responder
        req_t        r;
        logic [15:0] w;
        bus.mem_ack = 1'b0;
        bus.mem_rd  = 16'h0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                bus.mem_ack = inject_ack;
                bus.mem_rd  = inject_rd;
            end else begin
                bus.mem_ack = 1'b0;
                if (rst_n && bus.mem_req === 1'b1) begin
                    r.we = bus.mem_we; r.ad = bus.mem_ad; r.be = bus.mem_be; r.wd = bus.mem_wd;
                    req_log.push_back(r);
                    for (int i = 0; i < resp_lat; i++) begin
                        @(negedge clk);
                        if (bus.mem_req !== 1'b1 || bus.mem_we !== r.we || bus.mem_ad !== r.ad ||
                            bus.mem_be !== r.be || (r.we && bus.mem_wd !== r.wd)) hold_viol++;
                    end
                    if (r.we) begin
                        w = ctl_word(r.ad);
                        if (r.be[0]) w[7:0]  = r.wd[7:0];
                        if (r.be[1]) w[15:8] = r.wd[15:8];
                        mem_words[int'(r.ad)] = w;
                        bus.mem_rd = 16'($urandom);
                    end else begin
                        bus.mem_rd = ctl_word(r.ad);
                    end
                    bus.mem_ack = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic strobe(input bit rd, input logic [17:0] ra, input bit we,
                          input logic [17:0] wa, input logic [7:0] wd);
        @(negedge clk);
        bus.spr_rd = rd; bus.spr_ad = ra;
        bus.dl_we  = we; bus.dl_ad  = wa; bus.dl_dt = wd;
        @(posedge clk);
        #1;
        bus.spr_rd = 1'b0;
        bus.dl_we  = 1'b0;
    endtask

    task automatic wait_rdy(output int n, output bit ok);
        n  = 0;
        ok = (bus.spr_rdy === 1'b1);
        while (!ok && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.spr_rdy === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_not_busy(output int n, output bit ok);
        n  = 0;
        ok = (bus.dl_busy === 1'b0);
        while (!ok && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.dl_busy === 1'b0) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.spr_rd = 0; bus.spr_ad = 0; bus.dl_we = 0; bus.dl_ad = 0; bus.dl_dt = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.mem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_checks++; if (bus.mem_we !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.mem_ad !== 17'h0)  begin n_fail++; $display("FAIL reset_mem_ad: got %h want 0", bus.mem_ad); end
        n_checks++; if (bus.mem_be !== 2'b00)  begin n_fail++; $display("FAIL reset_mem_be: got %b want 00", bus.mem_be); end
        n_checks++; if (bus.mem_wd !== 16'h0)  begin n_fail++; $display("FAIL reset_mem_wd: got %h want 0", bus.mem_wd); end
        n_checks++; if (bus.spr_dt !== 8'h0)   begin n_fail++; $display("FAIL reset_spr_dt: got %h want 0", bus.spr_dt); end
        n_checks++; if (bus.spr_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_spr_rdy: got %b want 0", bus.spr_rdy); end
        n_checks++; if (bus.dl_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_dl_busy: got %b want 0", bus.dl_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: mem_req got %b want 0", bus.mem_req); end
        $display("txn reset released");
    endtask

    task automatic test_miss_read();
        int n; bit ok; int l0; int r0;
        mem_words[1] = 16'hA55A;
        shadow[2] = 8'h5A; shadow[3] = 8'hA5;
        resp_lat = 3;
        l0 = req_log.size(); r0 = rdy_count;
        strobe(1, 18'h00003, 0, 18'h0, 8'h0);
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL miss_req_rise: got %b want 1", bus.mem_req); end
        n_checks++; if (bus.mem_ad !== 17'h00001 || bus.mem_be !== 2'b11 || bus.mem_we !== 1'b0)
            begin n_fail++; $display("FAIL miss_mem_fields: ad %h be %b we %b want 00001 11 0", bus.mem_ad, bus.mem_be, bus.mem_we); end
        wait_rdy(n, ok);
        n_checks++; if (!ok || n != 4) begin n_fail++; $display("FAIL miss_latency: got %0d cycles (ok=%0d) want 4", n, ok); end
        n_checks++; if (bus.spr_dt !== 8'hA5) begin n_fail++; $display("FAIL miss_data: got %h want a5", bus.spr_dt); end
        @(posedge clk); #1;
        n_checks++; if (bus.spr_rdy !== 1'b0 || bus.spr_dt !== 8'hA5) begin n_fail++; $display("FAIL miss_rdy_pulse: rdy %b dt %h want 0 a5", bus.spr_rdy, bus.spr_dt); end
        n_checks++; if (req_log.size() - l0 != 1 || rdy_count - r0 != 1) begin n_fail++; $display("FAIL miss_counts: reqs %0d rdys %0d want 1 1", req_log.size() - l0, rdy_count - r0); end
        $display("txn miss read ad=00003 dt=%h cycles=%0d", bus.spr_dt, n);
    endtask

    task automatic test_write();
        int n; bit ok; int l0;
        resp_lat = 2;
        l0 = req_log.size();
        strobe(0, 18'h0, 1, 18'h20000, 8'h3C);
        shadow[32'h20000] = 8'h3C;
        n_checks++; if (bus.dl_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_rise: got %b want 1", bus.dl_busy); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_ad !== 17'h10000 || bus.mem_be !== 2'b01 || bus.mem_wd !== 16'h3C3C)
            begin n_fail++; $display("FAIL wr_mem_fields: req %b we %b ad %h be %b wd %h want 1 1 10000 01 3c3c", bus.mem_req, bus.mem_we, bus.mem_ad, bus.mem_be, bus.mem_wd); end
        wait_not_busy(n, ok);
        n_checks++; if (!ok || n != 3) begin n_fail++; $display("FAIL wr_busy_fall: got %0d cycles (ok=%0d) want 3", n, ok); end
        n_checks++; if (req_log.size() - l0 != 1) begin n_fail++; $display("FAIL wr_req_count: got %0d want 1", req_log.size() - l0); end
        $display("txn write ad=20000 dt=3c busy_cycles=%0d", n);
        resp_lat = 1;
        strobe(1, 18'h20000, 0, 18'h0, 8'h0);
        wait_rdy(n, ok);
        n_checks++; if (!ok || bus.spr_dt !== 8'h3C) begin n_fail++; $display("FAIL wr_readback_lo: got %h want 3c", bus.spr_dt); end
        strobe(1, 18'h20001, 0, 18'h0, 8'h0);
        wait_rdy(n, ok);
        n_checks++; if (!ok || bus.spr_dt !== ref_byte(18'h20001)) begin n_fail++; $display("FAIL wr_readback_hi: got %h want %h", bus.spr_dt, ref_byte(18'h20001)); end
        $display("txn readback 20000/20001 done");
    endtask

    task automatic test_collision();
        int n; bit ok; int l0; int r0; logic [7:0] d;
        resp_lat = 1;
        d = 8'($urandom) | 8'h81;
        l0 = req_log.size(); r0 = rdy_count;
        strobe(1, 18'h01235, 1, 18'h01235, d);
        shadow[32'h01235] = d;
        wait_rdy(n, ok);
        n_checks++; if (!ok || bus.spr_dt !== d) begin n_fail++; $display("FAIL coll_data: got %h want %h", bus.spr_dt, d); end
        wait_not_busy(n, ok);
        repeat (2) @(posedge clk); #1;
        n_checks++; if (req_log.size() - l0 != 2) begin n_fail++; $display("FAIL coll_req_count: got %0d want 2", req_log.size() - l0); end
        else begin
            n_checks++; if (req_log[l0].we !== 1'b1 || req_log[l0+1].we !== 1'b0)
                begin n_fail++; $display("FAIL coll_order: first we %b second we %b want 1 0", req_log[l0].we, req_log[l0+1].we); end
        end
        n_checks++; if (rdy_count - r0 != 1) begin n_fail++; $display("FAIL coll_rdy_count: got %0d want 1", rdy_count - r0); end
        $display("txn collision ad=01235 dt=%h", d);
    endtask

    task automatic test_back_to_back();
        int n; bit ok; int l0; int r0;
        resp_lat = 4;
        l0 = req_log.size(); r0 = rdy_count;
        strobe(1, 18'h00104, 0, 18'h0, 8'h0);
        strobe(1, 18'h00207, 0, 18'h0, 8'h0);
        wait_rdy(n, ok);
        n_checks++; if (!ok || bus.spr_dt !== ref_byte(18'h00104)) begin n_fail++; $display("FAIL b2b_data: got %h want %h", bus.spr_dt, ref_byte(18'h00104)); end
        repeat (6) @(posedge clk); #1;
        n_checks++; if (req_log.size() - l0 != 1 || rdy_count - r0 != 1)
            begin n_fail++; $display("FAIL b2b_counts: reqs %0d rdys %0d want 1 1", req_log.size() - l0, rdy_count - r0); end
        $display("txn back-to-back ad=00104 dt=%h", bus.spr_dt);
    endtask

    task automatic test_cache();
        int n; bit ok; int l0;
        resp_lat = 1;
        l0 = req_log.size();
        strobe(1, 18'h00002, 0, 18'h0, 8'h0);
        wait_rdy(n, ok);
        n_checks++; if (!ok || bus.spr_dt !== ref_byte(18'h00002)) begin n_fail++; $display("FAIL cache_first: got %h want %h", bus.spr_dt, ref_byte(18'h00002)); end
        strobe(1, 18'h00003, 0, 18'h0, 8'h0);
`ifdef SPRROM_CACHE_EN
        n_checks++; if (bus.spr_rdy !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL cache_hit_timing: rdy %b req %b want 1 0", bus.spr_rdy, bus.mem_req); end
`endif
        wait_rdy(n, ok);
        n_checks++; if (!ok || bus.spr_dt !== ref_byte(18'h00003)) begin n_fail++; $display("FAIL cache_second: got %h want %h", bus.spr_dt, ref_byte(18'h00003)); end
        repeat (3) @(posedge clk); #1;
`ifdef SPRROM_CACHE_EN
        n_checks++; if (req_log.size() - l0 != 1) begin n_fail++; $display("FAIL cache_req_count: got %0d want 1", req_log.size() - l0); end
`else
        n_checks++; if (req_log.size() - l0 != 2) begin n_fail++; $display("FAIL nocache_req_count: got %0d want 2", req_log.size() - l0); end
`endif
        strobe(0, 18'h0, 1, 18'h00002, 8'h77);
        shadow[2] = 8'h77;
        wait_not_busy(n, ok);
        l0 = req_log.size();
        strobe(1, 18'h00003, 0, 18'h0, 8'h0);
        wait_rdy(n, ok);
        repeat (2) @(posedge clk); #1;
        n_checks++; if (req_log.size() - l0 != 1) begin n_fail++; $display("FAIL cache_inval_refetch: got %0d reqs want 1", req_log.size() - l0); end
        n_checks++; if (bus.spr_dt !== ref_byte(18'h00003)) begin n_fail++; $display("FAIL cache_inval_data: got %h want %h", bus.spr_dt, ref_byte(18'h00003)); end
        $display("txn cache sequence done");
    endtask

    task automatic test_reset_mid();
        int r0;
        @(negedge clk);
        resp_en = 1'b0; inject_ack = 1'b0; inject_rd = 16'h0;
        strobe(1, 18'h00011, 0, 18'h0, 8'h0);
        repeat (2) @(posedge clk); #1;
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_pending: got %b want 1", bus.mem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_ad !== 17'h0 || bus.mem_be !== 2'b00 || bus.mem_wd !== 16'h0)
            begin n_fail++; $display("FAIL rmid_mem_clear: req %b ad %h be %b wd %h want all 0", bus.mem_req, bus.mem_ad, bus.mem_be, bus.mem_wd); end
        n_checks++; if (bus.spr_dt !== 8'h0 || bus.spr_rdy !== 1'b0 || bus.dl_busy !== 1'b0)
            begin n_fail++; $display("FAIL rmid_out_clear: dt %h rdy %b busy %b want 0 0 0", bus.spr_dt, bus.spr_rdy, bus.dl_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rdy_count;
        inject_rd = 16'hFFFF; inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        repeat (5) @(posedge clk); #1;
        n_checks++; if (rdy_count != r0 || bus.spr_dt !== 8'h0) begin n_fail++; $display("FAIL rmid_late_ack: rdys %0d dt %h want 0 00", rdy_count - r0, bus.spr_dt); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_after: got %b want 0", bus.mem_req); end
        @(negedge clk);
        resp_en = 1'b1;
        $display("txn reset mid-read done");
    endtask

    task automatic test_random();
        int n, l0, r0, exp_acc, kind, lat, ri;
        bit ok, miss;
        logic [17:0] ra, wa;
        logic [7:0]  d, exp_val;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mc_valid = 1'b0;
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 2);
            ra = 18'($urandom_range(0, 47)); if ($urandom_range(0, 3) == 0) ra = ra | 18'h3FFC0;
            wa = 18'($urandom_range(0, 47)); if ($urandom_range(0, 3) == 0) wa = wa | 18'h3FFC0;
            d = 8'($urandom);
            lat = $urandom_range(0, 3);
            resp_lat = lat;
            l0 = req_log.size(); r0 = rdy_count;
            exp_acc = 0; miss = 1'b0; exp_val = 8'h0;
            if (kind != 0) begin
                shadow[int'(wa)] = d;
                exp_acc++;
                if (mc_valid && mc_tag == wa[17:1]) mc_valid = 1'b0;
            end
            if (kind != 1) begin
                miss = !model_hit(ra);
                exp_val = ref_byte(ra);
                if (miss) begin
                    exp_acc++;
                    mc_valid = 1'b1; mc_tag = ra[17:1];
                end
            end
            strobe(kind != 1, ra, kind != 0, wa, d);
            if (kind != 0) begin
                n_checks++; if (bus.dl_busy !== 1'b1) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want 1", k, bus.dl_busy); end
            end
            if (kind != 1) begin
                wait_rdy(n, ok);
                n_checks++; if (!ok || bus.spr_dt !== exp_val) begin n_fail++; $display("FAIL rnd_read[%0d]: ad %h got %h want %h ok %0d", k, ra, bus.spr_dt, exp_val, ok); end
                if (kind == 0) begin
                    n_checks++; if (n != (miss ? lat + 1 : 0)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, n, miss ? lat + 1 : 0); end
                end
            end
            wait_not_busy(n, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_busy_timeout[%0d]: busy stuck", k); end
            @(posedge clk); #1;
            n_checks++; if (req_log.size() - l0 != exp_acc || rdy_count - r0 != int'(kind != 1))
                begin n_fail++; $display("FAIL rnd_counts[%0d]: reqs %0d rdys %0d want %0d %0d", k, req_log.size() - l0, rdy_count - r0, exp_acc, int'(kind != 1)); end
            else begin
                if (kind != 0) begin
                    n_checks++; if (req_log[l0].we !== 1'b1 || req_log[l0].ad !== wa[17:1] || req_log[l0].be !== (wa[0] ? 2'b10 : 2'b01) || req_log[l0].wd !== {d, d})
                        begin n_fail++; $display("FAIL rnd_wr_fields[%0d]: we %b ad %h be %b wd %h", k, req_log[l0].we, req_log[l0].ad, req_log[l0].be, req_log[l0].wd); end
                end
                if (kind != 1 && miss) begin
                    ri = l0 + int'(kind != 0);
                    n_checks++; if (req_log[ri].we !== 1'b0 || req_log[ri].ad !== ra[17:1] || req_log[ri].be !== 2'b11)
                        begin n_fail++; $display("FAIL rnd_rd_fields[%0d]: we %b ad %h be %b", k, req_log[ri].we, req_log[ri].ad, req_log[ri].be); end
                end
            end
            $display("txn rnd %0d kind=%0d ra=%h wa=%h d=%h lat=%0d", k, kind, ra, wa, d, lat);
        end
        n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL mem_hold_stable: got %0d violations want 0", hold_viol); end
    endtask

    initial begin : main
        test_reset();
        test_miss_read();
        test_write();
        test_collision();
        test_back_to_back();
        test_cache();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
